icon_sprite_engine: RTL and testbench

Parametrised successor to the single-size tank icon renderer in the rojobot display path. Given the current VGA pixel coordinates and the robot's location and heading registers, it produces the icon colour for each pixel. It supports configurable icon size, screen scaling, all 8 headings and a transparency key. Position and heading are latched once per frame so the icon never tears, and the pipeline latency is fixed. It sits between the rojobot register interface and the colourizer/VGA mixer.

---
 rtl/icon_pkg.sv | 16 +
 rtl/icon_rom.sv | 31 +++
 rtl/icon_sprite_engine.sv | 152 +++++++++++++++
 tb/tb_icon_sprite_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/icon_pkg.sv
// Shared types and helpers for the rojobot icon sprite engine.
package icon_pkg;

    typedef enum logic [2:0] {
        HDG_N, HDG_NE, HDG_E, HDG_SE, HDG_S, HDG_SW, HDG_W, HDG_NW
    } heading_e;

    localparam int ICON_COLOR_W = 12;
    localparam logic [ICON_COLOR_W-1:0] ICON_TRANSPARENT = 12'h000;

    // ROM address = {heading, dy, dx}
    function automatic int icon_addr_w(input int w, input int h);
        return 3 + $clog2(w) + $clog2(h);
    endfunction

endpackage

// File: rtl/icon_rom.sv
// Synchronous single-port icon ROM, 8 headings x ICON_H x ICON_W, 1-cycle read.
// Image: word = {address,1'b1}, with each heading's top-left pixel transparent.
module icon_rom
    import icon_pkg::*;
#(
    parameter int                  ICON_W      = 16,
    parameter int                  ICON_H      = 16,
    parameter int                  COLOR_W     = ICON_COLOR_W,
    parameter logic [COLOR_W-1:0]  TRANSPARENT = ICON_TRANSPARENT,
    localparam int                 AW          = icon_addr_w(ICON_W, ICON_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      addr,
    output logic [COLOR_W-1:0] data
);

    function automatic logic [COLOR_W-1:0] rom_word(input logic [AW-1:0] a);
        if (a[AW-4:0] == '0)
            return TRANSPARENT;
        return COLOR_W'({a, 1'b1});
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            data <= '0;
        else
            data <= rom_word(addr);
    end

endmodule

// File: rtl/icon_sprite_engine.sv
// Rojobot icon renderer: frame-latched position/heading, 3-clock pixel pipeline.
// Optional blinking is compiled in with `define ICON_BLINK_EN.
module icon_sprite_engine
    import icon_pkg::*;
#(
    parameter int                  ICON_W       = 16,
    parameter int                  ICON_H       = 16,
    parameter int                  SCALE_X      = 8,
    parameter int                  SCALE_Y      = 6,
    parameter int                  PIX_W        = 12,
    parameter int                  COLOR_W      = ICON_COLOR_W,
    parameter logic [COLOR_W-1:0]  TRANSPARENT  = ICON_TRANSPARENT,
    parameter int                  BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIX_W-1:0]   pixel_column,
    input  logic [PIX_W-1:0]   pixel_row,
    input  logic [7:0]         LocX_reg,
    input  logic [7:0]         LocY_reg,
    input  logic [7:0]         BotInfo_reg,
    input  logic               blink_req,
    output logic [COLOR_W-1:0] icon,
    output logic               icon_valid
);

    localparam int XB     = $clog2(ICON_W);
    localparam int YB     = $clog2(ICON_H);
    localparam int AW     = icon_addr_w(ICON_W, ICON_H);
    localparam int STAGES = 1;

    logic             frame_start;
    logic [PIX_W:0]   pos_x, pos_y;
    heading_e         heading;
    logic             pos_valid;
    logic             draw_ok;

    assign frame_start = (pixel_row == '0) && (pixel_column == '0);

    // Frame-start latch; everything downstream sees only these copies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_x     <= '0;
            pos_y     <= '0;
            heading   <= HDG_N;
            pos_valid <= 1'b0;
        end else if (frame_start) begin
            pos_x     <= (PIX_W+1)'(LocX_reg) * (PIX_W+1)'(SCALE_X);
            pos_y     <= (PIX_W+1)'(LocY_reg) * (PIX_W+1)'(SCALE_Y);
            heading   <= heading_e'(BotInfo_reg[2:0]);
            pos_valid <= 1'b1;
        end
    end

`ifdef ICON_BLINK_EN
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BCW-1:0] blink_cnt;
    logic           blink_phase;
    logic           blank_frame;

    // blank_frame holds the decision for the frame just started.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            blank_frame <= 1'b0;
        end else if (frame_start) begin
            if (!blink_req) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
                blank_frame <= 1'b0;
            end else begin
                blank_frame <= blink_phase;
                if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign draw_ok = !blank_frame;
`else
    logic unused_blink;
    assign unused_blink = blink_req ^ (BLINK_FRAMES > 0);
    assign draw_ok      = 1'b1;
`endif

    logic unused_botinfo;
    assign unused_botinfo = ^BotInfo_reg[7:3];

    // Stage 1: hit test and address straight from coordinates.
    logic [PIX_W:0] col_x, row_y, end_x, end_y;
    logic           hit;
    logic [XB-1:0]  dx;
    logic [YB-1:0]  dy;

    assign col_x = {1'b0, pixel_column};
    assign row_y = {1'b0, pixel_row};
    assign end_x = pos_x + (PIX_W+1)'(ICON_W);
    assign end_y = pos_y + (PIX_W+1)'(ICON_H);
    assign hit   = pos_valid && draw_ok &&
                   (col_x >= pos_x) && (col_x < end_x) &&
                   (row_y >= pos_y) && (row_y < end_y);
    assign dx    = XB'(col_x - pos_x);
    assign dy    = YB'(row_y - pos_y);

    logic [AW-1:0]     addr1;
    logic [STAGES:0]   vld_pipe;
    logic [COLOR_W-1:0] rom_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr1    <= '0;
            vld_pipe <= '0;
        end else begin
            addr1    <= {heading, dy, dx};
            vld_pipe <= {vld_pipe[STAGES-1:0], hit};
        end
    end

    // Stage 2: ROM read, hit follows in vld_pipe.
    icon_rom #(
        .ICON_W      (ICON_W),
        .ICON_H      (ICON_H),
        .COLOR_W     (COLOR_W),
        .TRANSPARENT (TRANSPARENT)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (addr1),
        .data  (rom_data)
    );

    // Stage 3: colour-key compare and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icon       <= '0;
            icon_valid <= 1'b0;
        end else if (vld_pipe[STAGES] && (rom_data != TRANSPARENT)) begin
            icon       <= rom_data;
            icon_valid <= 1'b1;
        end else begin
            icon       <= '0;
            icon_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_icon_sprite_engine.sv
// Scoreboard bench for icon_sprite_engine: every driven pixel gets an expected
// {icon_valid, icon} pushed with its due cycle, compared 3 clocks later.
module tb_icon_sprite_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] pixel_column = '0;
    logic [11:0] pixel_row = '0;
    logic [7:0]  LocX_reg = '0;
    logic [7:0]  LocY_reg = '0;
    logic [7:0]  BotInfo_reg = '0;
    logic        blink_req = 1'b0;
    logic [11:0] icon;
    logic        icon_valid;

    icon_sprite_engine #(.BLINK_FRAMES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_column (pixel_column),
        .pixel_row    (pixel_row),
        .LocX_reg     (LocX_reg),
        .LocY_reg     (LocY_reg),
        .BotInfo_reg  (BotInfo_reg),
        .blink_req    (blink_req),
        .icon         (icon),
        .icon_valid   (icon_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [12:0] exp;
        int          due;
        string       tag;
    } sb_t;
    sb_t sb[$];

    // Reference model state
    int m_px = 0, m_py = 0, m_h = 0;
    bit m_pv = 0, m_blank = 0, nxt_blank = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ROM image: word {heading,dy,dx,1}, top-left pixel of each heading transparent
    function automatic logic [11:0] rom_img(input int h, input int dy, input int dx);
        if (dx == 0 && dy == 0) return 12'h000;
        return 12'(h * 512 + dy * 32 + dx * 2 + 1);
    endfunction

    function automatic logic [12:0] model(input int c, input int r);
        logic [11:0] w;
        if (!m_pv || m_blank) return 13'h0;
        if (c < m_px || c >= m_px + 16 || r < m_py || r >= m_py + 16) return 13'h0;
        w = rom_img(m_h, r - m_py, c - m_px);
        if (w == 12'h000) return 13'h0;
        return {1'b1, w};
    endfunction

    task automatic drive(input int c, input int r, input string tag);
        sb_t e;
        @(negedge clk);
        pixel_column = 12'(c);
        pixel_row    = 12'(r);
        e.exp = model(c, r);
        e.due = cyc + 3;
        e.tag = tag;
        sb.push_back(e);
        if (c == 0 && r == 0 && reset) begin
            m_px    = LocX_reg * 8;
            m_py    = LocY_reg * 6;
            m_h     = BotInfo_reg[2:0];
            m_pv    = 1;
            m_blank = nxt_blank;
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset = 1'b0;
        m_pv = 0; m_blank = 0; m_px = 0; m_py = 0; m_h = 0;
        foreach (sb[i]) sb[i].exp = 13'h0;
        #1 check("rst_async", {icon_valid, icon}, 13'h0);
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            check(e.tag, {icon_valid, icon}, e.exp);
        end
    end

    initial begin
        int pat[6];
        pat = '{0, 0, 1, 1, 0, 0};

        repeat (3) @(negedge clk);
        check("rst_state", {icon_valid, icon}, 13'h0);
        reset = 1'b1;

        // No latch yet: nothing drawn
        drive(81, 60, "pre_frame");

        // Basic draw
        LocX_reg = 8'd10; LocY_reg = 8'd10; BotInfo_reg = 8'd0;
        drive(0, 0, "fs_basic");
        drive(80, 60, "transp_80_60");
        drive(81, 60, "basic_81_60");
        drive(95, 75, "basic_95_75");
        drive(96, 60, "basic_right");
        drive(79, 60, "basic_left");
        drive(80, 59, "basic_top");
        drive(80, 76, "basic_bot");
        drive(88, 70, "basic_mid");
        drive(80, 61, "basic_80_61");

        // Tear-free: change mid-frame
        LocX_reg = 8'd20;
        drive(0, 100, "tear_row100");
        drive(81, 60, "tear_old_box");
        drive(161, 60, "tear_new_early");
        drive(0, 0, "fs_tear");
        drive(81, 60, "tear_old_gone");
        drive(161, 60, "tear_new_box");
        drive(175, 75, "tear_new_corner");

        // Heading coverage with junk in upper BotInfo bits
        for (int h = 0; h < 8; h++) begin
            BotInfo_reg = {5'b10101, 3'(h)};
            drive(0, 0, "fs_hdg");
            drive(161, 60, $sformatf("hdg%0d_base", h));
            drive(170, 65, $sformatf("hdg%0d_mid", h));
        end

        // Edge: pos_x = 2040, no wrap to column 0
        LocX_reg = 8'd255; BotInfo_reg = 8'd2;
        drive(0, 0, "fs_edge");
        drive(2040, 60, "edge_first");
        drive(2041, 60, "edge_2041");
        drive(2055, 75, "edge_last");
        drive(2056, 60, "edge_past");
        drive(2039, 60, "edge_before");
        drive(0, 61, "edge_nowrap0");
        drive(7, 61, "edge_nowrap7");
        repeat (4) drive(2041, 61, "edge_hold");

        // Mid-frame reset while output is drawing
        assert_reset();
        repeat (2) drive(2041, 61, "in_reset");
        @(negedge clk) reset = 1'b1;
        repeat (3) drive(2041, 61, "post_rst");
        drive(0, 0, "fs_post_rst");
        drive(2041, 61, "post_rst_draw");
        drive(2042, 62, "post_rst_draw2");

`ifdef ICON_BLINK_EN
        assert_reset();
        @(negedge clk) reset = 1'b1;
        blink_req = 1'b1;
        for (int f = 0; f < 6; f++) begin
            nxt_blank = pat[f][0];
            drive(0, 0, "fs_blink");
            drive(2041, 61, $sformatf("blink_f%0d", f));
        end
        blink_req = 1'b0;
        nxt_blank = 0;
        drive(0, 0, "fs_unblink");
        drive(2041, 61, "unblink_draw");
`else
        blink_req = 1'b1;
        drive(0, 0, "fs_noblink");
        drive(2041, 61, "noblink_draw");
        drive(0, 0, "fs_noblink2");
        drive(2041, 61, "noblink_draw2");
        blink_req = 1'b0;
`endif

        repeat (6) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
